mem_responder: RTL and testbench

Data-memory responder on the far side of the CPU load/store interface. It accepts one load or store request per handshake from the CPU control FSM, models a configurable number of memory wait states, and performs the access on an internal single-port synchronous RAM. It returns exactly one response per request, with read data for loads. It sits between the CPU datapath load/store port and data storage, and replaces the direct-wired `WE`/`Lscntl` memory path.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_bram.sv | 29 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and width helpers for the data-memory responder.
// Used by mem_responder and its testbench-facing interface.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    // Width needed to hold v distinct values, never narrower than 1 bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Wait counter must hold values 0..wait_cycles.
    function automatic int cnt_w(input int wait_cycles);
        return clog2_min1(wait_cycles + 1);
    endfunction

    // RAM index width for a power-of-two depth.
    function automatic int idx_w(input int depth);
        return clog2_min1(depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU load/store request/response bundle.
// master = CPU side, slave = mem_responder side.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_bram.sv
// Single-port synchronous RAM, 1-cycle registered read, no reset.
// Written in the plain form synthesis maps onto block RAM.
module mem_bram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Enabled access: write-first is not needed, read returns old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: request latch, wait-state FSM, RAM, response regs.
// Define MEM_RANGE_CHECK_EN to flag addresses >= DEPTH instead of aliasing.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);
    localparam int CNT_W = cnt_w(WAIT_CYCLES);
    localparam int IDX_W = idx_w(DEPTH);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              addr_err;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_RANGE_CHECK_EN
    assign addr_err = |(addr_q >> IDX_W);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |(addr_q >> IDX_W);
    assign addr_err       = 1'b0;
`endif

    assign ram_en        = (state_q == ACCESS) && !addr_err;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Request FSM: accept in IDLE, count wait states, one RAM cycle, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ACCESS;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: state_q <= RESP;
                RESP:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response registers: loaded from the RESP cycle, so they pulse once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == RESP);
            rsp_err_q   <= (state_q == RESP) && addr_err;
            if ((state_q == RESP) && !we_q && !addr_err) begin
                rsp_rdata_q <= ram_rdata;
            end else begin
                rsp_rdata_q <= '0;
            end
        end
    end

    mem_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder (WAIT_CYCLES 1 and 0).
// Reference model: word array with known flags, latency/period from rules.
module tb_mem_responder;
    logic clk;
    logic reset;

    logic [1:0]  t_valid;
    logic [1:0]  t_we;
    logic [15:0] t_addr  [2];
    logic [15:0] t_wdata [2];

    int n_cmp;
    int n_err;
    int cyc;

    logic [15:0] mdl   [2][1024];
    bit          known [2][1024];

    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

    assign bus0.req_valid = t_valid[0];
    assign bus0.req_we    = t_we[0];
    assign bus0.req_addr  = t_addr[0];
    assign bus0.req_wdata = t_wdata[0];
    assign bus1.req_valid = t_valid[1];
    assign bus1.req_we    = t_we[1];
    assign bus1.req_addr  = t_addr[1];
    assign bus1.req_wdata = t_wdata[1];

    mem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(1)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic f_rdy(int k);
        return (k == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    function automatic logic f_busy(int k);
        return (k == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic f_rv(int k);
        return (k == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction

    function automatic logic [15:0] f_rd(int k);
        return (k == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    endfunction

    function automatic logic f_err(int k);
        return (k == 0) ? bus0.rsp_err : bus1.rsp_err;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drv(int k, bit v, bit we, logic [15:0] a, logic [15:0] d);
        t_valid[k] = v;
        t_we[k]    = we;
        t_addr[k]  = a;
        t_wdata[k] = d;
    endtask

    // One request through the model: latency, pulse width, data, error.
    task automatic txn(int k, bit we, logic [15:0] a, logic [15:0] d);
        int          n;
        int          idx;
        bit          e_err;
        bit          chk_rd;
        logic [15:0] e_rd;
        idx = int'(a) % 1024;
`ifdef MEM_RANGE_CHECK_EN
        e_err = (int'(a) >= 1024);
`else
        e_err = 1'b0;
`endif
        chk_rd = 1'b1;
        e_rd   = 16'h0;
        if (!e_err && !we) begin
            chk_rd = known[k][idx];
            e_rd   = mdl[k][idx];
        end
        n = 0;
        @(negedge clk);
        while (!f_rdy(k) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 0, 1);
        drv(k, 1'b1, we, a, d);
        @(posedge clk);
        #1;
        drv(k, 1'b0, 1'b0, 16'h0, 16'h0);
        if (!e_err && we) begin
            mdl[k][idx]   = d;
            known[k][idx] = 1'b1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!f_rv(k) && n < 20);
        check($sformatf("lat_k%0d", k), n, wc(k) + 2);
        check($sformatf("err_k%0d_a%0h", k, a), f_err(k), e_err);
        if (chk_rd) check($sformatf("rd_k%0d_a%0h", k, a), f_rd(k), e_rd);
        @(posedge clk);
        #1;
        check($sformatf("pulse_k%0d", k), f_rv(k), 0);
    endtask

    // Hold req_valid high with junk while busy: junk must be ignored.
    task automatic hold_test(int k);
        int          acc[$];
        int          nreq;
        int          rsp_n;
        int          bad;
        int          nbusy;
        logic [15:0] d1;
        logic [15:0] last_rd;
        d1      = 16'($urandom);
        nreq    = 0;
        rsp_n   = 0;
        bad     = 0;
        nbusy   = 0;
        last_rd = 16'h0;
        for (int c = 0; c < 4 * (wc(k) + 3) + 4; c++) begin
            @(negedge clk);
            if (f_rv(k)) begin
                rsp_n++;
                last_rd = f_rd(k);
            end
            if (f_rdy(k) == f_busy(k)) bad++;
            if (!f_rdy(k)) nbusy++;
            if (f_rdy(k)) begin
                if (nreq == 0) drv(k, 1'b1, 1'b1, 16'h0030, d1);
                else if (nreq == 1) drv(k, 1'b1, 1'b0, 16'h0030, 16'h0);
                else drv(k, 1'b0, 1'b0, 16'h0, 16'h0);
                if (nreq < 2) begin
                    acc.push_back(cyc);
                    nreq++;
                end
            end else begin
                drv(k, 1'b1, 1'b1, 16'h0030 + 16'(c & 1), d1 ^ (16'($urandom) | 16'h1));
            end
        end
        drv(k, 1'b0, 1'b0, 16'h0, 16'h0);
        mdl[k][16'h30]   = d1;
        known[k][16'h30] = 1'b1;
        check($sformatf("hold_nreq_k%0d", k), nreq, 2);
        if (acc.size() == 2)
            check($sformatf("period_k%0d", k), acc[1] - acc[0], wc(k) + 3);
        check($sformatf("hold_rsps_k%0d", k), rsp_n, 2);
        check($sformatf("hold_rd_k%0d", k), last_rd, d1);
        check($sformatf("rdy_vs_busy_k%0d", k), bad, 0);
        check($sformatf("busy_cycles_k%0d", k), nbusy, 2 * (wc(k) + 2));
    endtask

    initial begin
        int          seen;
        logic [15:0] a;
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        t_valid = '0;
        t_we    = '0;
        for (int k = 0; k < 2; k++) begin
            t_addr[k]  = '0;
            t_wdata[k] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ready_k%0d", k), f_rdy(k), 1);
            check($sformatf("rst_busy_k%0d", k), f_busy(k), 0);
            check($sformatf("rst_rv_k%0d", k), f_rv(k), 0);
            check($sformatf("rst_err_k%0d", k), f_err(k), 0);
            check($sformatf("rst_rd_k%0d", k), f_rd(k), 0);
        end

        txn(0, 1'b1, 16'h0010, 16'h00A5);
        txn(0, 1'b0, 16'h0010, 16'h0000);
        hold_test(0);
        txn(0, 1'b1, 16'h0410, 16'h1234);
        txn(0, 1'b0, 16'h0010, 16'h0000);

        txn(0, 1'b1, 16'h0020, 16'h1111);
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        @(posedge clk);
        #1;
        drv(0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("abort_busy", f_busy(0), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_async_ready", f_rdy(0), 1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (f_rv(0)) seen++;
        end
        check("abort_no_rsp", seen, 0);
        txn(0, 1'b0, 16'h0020, 16'h0000);

        txn(1, 1'b1, 16'h0055, 16'h5AA5);
        txn(1, 1'b0, 16'h0055, 16'h0000);
        hold_test(1);
        txn(1, 1'b1, 16'h8055, 16'hC3C3);
        txn(1, 1'b0, 16'h0055, 16'h0000);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                a = 16'h0040 + 16'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0)
                    a = a | (16'h0400 << $urandom_range(0, 5));
                txn(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
